// File: rtl/inst_sram_axi_rd_bridge_pkg.sv
// Shared constants and types for the instruction-fetch SRAM-to-AXI read bridge.
package inst_sram_axi_rd_bridge_pkg;

   localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
   localparam logic [2:0] AXI_SIZE_WORD   = 3'b010;
   localparam logic [7:0] AXI_LEN_2BEAT   = 8'd1;
   localparam logic [3:0] ARID_INST       = 4'd0;
   localparam int         INST_PAIR_WIDTH = 64;

   typedef enum logic {
      BEAT0 = 1'b0,
      BEAT1 = 1'b1
   } beat_state_e;

endpackage

// File: rtl/inst_sram_axi_rd_bridge_if.sv
// Fetch-side request/response signals plus the AXI AR/R channels of the bridge.
interface inst_sram_axi_rd_bridge_if;
   import inst_sram_axi_rd_bridge_pkg::*;

   logic                       inst_sram_req;
   logic [31:0]                inst_sram_raddr;
   logic                       excep_flush;
   logic                       inst_ram_addr_ok;
   logic                       inst_ram_data_ok;
   logic [INST_PAIR_WIDTH-1:0] inst_ram_rdata;

   logic [3:0]                 arid;
   logic [31:0]                araddr;
   logic [7:0]                 arlen;
   logic [2:0]                 arsize;
   logic [1:0]                 arburst;
   logic                       arvalid;
   logic                       arready;

   logic [3:0]                 rid;
   logic [31:0]                rdata;
   logic [1:0]                 rresp;
   logic                       rlast;
   logic                       rvalid;
   logic                       rready;

   // The bridge side: responder to the fetch stage, AXI read master.
   modport master (
      input  inst_sram_req, inst_sram_raddr, excep_flush,
      output inst_ram_addr_ok, inst_ram_data_ok, inst_ram_rdata,
      output arid, araddr, arlen, arsize, arburst, arvalid,
      input  arready,
      input  rid, rdata, rresp, rlast, rvalid,
      output rready
   );

   modport slave (
      output inst_sram_req, inst_sram_raddr, excep_flush,
      input  inst_ram_addr_ok, inst_ram_data_ok, inst_ram_rdata,
      input  arid, araddr, arlen, arsize, arburst, arvalid,
      output arready,
      output rid, rdata, rresp, rlast, rvalid,
      input  rready
   );

endinterface

// File: rtl/inst_sram_axi_rd_bridge_rbeat_pack.sv
// Packs the two R beats of a fetch into one 64-bit instruction pair.
module inst_rbeat_pack
   import inst_sram_axi_rd_bridge_pkg::*;
(
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       beat_valid,
   input  logic                       beat_last,
   input  logic [31:0]                beat_data,
   output logic                       pair_done,
   output logic [INST_PAIR_WIDTH-1:0] pair_data
);

   beat_state_e state_q, state_d;
   logic [31:0] lo_q, lo_d;

   // An early rlast in BEAT0 is closed out as a pair using the stale low word.
   always_comb begin
      state_d   = state_q;
      lo_d      = lo_q;
      pair_done = 1'b0;
      case (state_q)
         BEAT0: begin
            if (beat_valid) begin
               if (beat_last) begin
                  pair_done = 1'b1;
               end else begin
                  lo_d    = beat_data;
                  state_d = BEAT1;
               end
            end
         end
         BEAT1: begin
            if (beat_valid && beat_last) begin
               pair_done = 1'b1;
               state_d   = BEAT0;
            end
         end
      endcase
   end

   assign pair_data = {beat_data, lo_q};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= BEAT0;
         lo_q    <= 32'd0;
      end else begin
         state_q <= state_d;
         lo_q    <= lo_d;
      end
   end

endmodule

// File: rtl/inst_sram_axi_rd_bridge.sv
// Turns each accepted fetch into a 2-beat AXI INCR read and returns the
// instruction pair, dropping responses made stale by a pipeline flush.
module inst_sram_axi_rd_bridge
   import inst_sram_axi_rd_bridge_pkg::*;
#(
   parameter int         MAX_OUT = 2,
   parameter logic [3:0] AXI_ID  = ARID_INST
) (
   input  logic                      clk,
   input  logic                      rst,
   inst_sram_axi_rd_bridge_if.master bus
);

   localparam logic [1:0] MAX_OUT_C = 2'(MAX_OUT);

   logic                       arvalid_q, arvalid_d;
   logic [31:0]                araddr_q, araddr_d;
   logic                       rready_q;
   logic [1:0]                 out_cnt_q, out_cnt_d;
   logic [1:0]                 cancel_cnt_q, cancel_cnt_d;
   logic                       addr_ok;
   logic                       r_hs;
   logic                       pair_done;
   logic [INST_PAIR_WIDTH-1:0] pair_data;
   logic                       data_ok;
   logic                       unused_axi;

   assign unused_axi = ^{bus.rid, bus.rresp};

   assign addr_ok = bus.inst_sram_req & (~arvalid_q | bus.arready) & (out_cnt_q < MAX_OUT_C);
   assign r_hs    = bus.rvalid & rready_q;

   inst_rbeat_pack u_pack (
      .clk        (clk),
      .rst        (rst),
      .beat_valid (r_hs),
      .beat_last  (bus.rlast),
      .beat_data  (bus.rdata),
      .pair_done  (pair_done),
      .pair_data  (pair_data)
   );

   // A flush marks everything still owed after this cycle as stale, including
   // an accept made in the flush cycle; each stale completion burns one count.
   always_comb begin
      arvalid_d = arvalid_q;
      araddr_d  = araddr_q;
      if (addr_ok) begin
         arvalid_d = 1'b1;
         araddr_d  = bus.inst_sram_raddr;
      end else if (bus.arready) begin
         arvalid_d = 1'b0;
      end

      out_cnt_d = out_cnt_q;
      if (addr_ok && !pair_done) begin
         out_cnt_d = out_cnt_q + 2'd1;
      end else if (!addr_ok && pair_done && (out_cnt_q != 2'd0)) begin
         out_cnt_d = out_cnt_q - 2'd1;
      end

      cancel_cnt_d = cancel_cnt_q;
      data_ok      = 1'b0;
      if (bus.excep_flush) begin
         cancel_cnt_d = out_cnt_d;
      end else if (pair_done) begin
         if (cancel_cnt_q != 2'd0) begin
            cancel_cnt_d = cancel_cnt_q - 2'd1;
         end else begin
            data_ok = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         arvalid_q    <= 1'b0;
         araddr_q     <= 32'd0;
         rready_q     <= 1'b0;
         out_cnt_q    <= 2'd0;
         cancel_cnt_q <= 2'd0;
      end else begin
         arvalid_q    <= arvalid_d;
         araddr_q     <= araddr_d;
         rready_q     <= 1'b1;
         out_cnt_q    <= out_cnt_d;
         cancel_cnt_q <= cancel_cnt_d;
      end
   end

   assign bus.inst_ram_addr_ok = addr_ok;
   assign bus.inst_ram_data_ok = data_ok;
   assign bus.inst_ram_rdata   = pair_data;
   assign bus.arid             = AXI_ID;
   assign bus.araddr           = araddr_q;
   assign bus.arlen            = AXI_LEN_2BEAT;
   assign bus.arsize           = AXI_SIZE_WORD;
   assign bus.arburst          = AXI_BURST_INCR;
   assign bus.arvalid          = arvalid_q;
   assign bus.rready           = rready_q;

endmodule

// File: tb/tb_inst_sram_axi_rd_bridge.sv
// Bench for inst_sram_axi_rd_bridge: directed scenarios plus random traffic
// against a request-queue model and a memory-backed AXI slave.
module tb_inst_sram_axi_rd_bridge;
   import inst_sram_axi_rd_bridge_pkg::*;

   localparam int MAX_OUT = 2;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   inst_sram_axi_rd_bridge_if bus ();

   inst_sram_axi_rd_bridge #(
      .MAX_OUT (MAX_OUT),
      .AXI_ID  (ARID_INST)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      logic [31:0] addr;
      bit          stale;
   } fetch_t;

   int vectors     = 0;
   int miscompares = 0;

   logic [31:0] mem [logic [31:0]];

   int          arreadyMode;
   bit          rHold;
   bit          rFull;
   logic [31:0] arQ [$];
   bit          beatIdx;

   fetch_t      modelQ [$];
   logic        expArvalid;
   logic [31:0] expAraddr;
   logic        expRready;

   int          dataOkCount      = 0;
   int          addrOkCount      = 0;
   int          cycleCnt         = 0;
   int          lastAddrOkCycle  = 0;
   int          lastDataOkCycle  = 0;
   logic [63:0] lastRdata        = 64'd0;

   function automatic logic [31:0] memRead(input logic [31:0] a);
      if (mem.exists(a)) return mem[a];
      return {a[15:0], a[31:16]} ^ 32'hC0DE_F00D;
   endfunction

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic applyStimulus(input logic req, input logic [31:0] addr, input logic flush,
                                output logic acc);
      @(negedge clk);
      bus.inst_sram_req   = req;
      bus.inst_sram_raddr = addr;
      bus.excep_flush     = flush;
      #1;
      acc = bus.inst_ram_addr_ok;
   endtask

   task automatic doReset();
      @(negedge clk);
      rst                 = 1'b1;
      bus.inst_sram_req   = 1'b0;
      bus.excep_flush     = 1'b0;
      #1;
      checkOutput("rst_now_arvalid", 64'(bus.arvalid), 64'd0);
      checkOutput("rst_now_araddr", 64'(bus.araddr), 64'd0);
      checkOutput("rst_now_data_ok", 64'(bus.inst_ram_data_ok), 64'd0);
      checkOutput("rst_now_rready", 64'(bus.rready), 64'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic fetchOne(input logic [31:0] addr);
      logic acc;
      acc = 1'b0;
      for (int i = 0; i < 60 && !acc; i++) applyStimulus(1'b1, addr, 1'b0, acc);
      if (!acc) checkOutput("accept_timeout", 64'(acc), 64'd1);
   endtask

   task automatic waitIdle();
      logic acc;
      int   n;
      n = 0;
      do begin
         applyStimulus(1'b0, 32'd0, 1'b0, acc);
         n++;
      end while (n < 400 && (modelQ.size() != 0 || arQ.size() != 0 || expArvalid));
      if (n >= 400) checkOutput("idle_timeout", 64'(modelQ.size()), 64'd0);
   endtask

   // Memory-backed AXI slave: queues accepted AR addresses, returns two beats each.
   initial begin
      bus.arready = 1'b0;
      bus.rvalid  = 1'b0;
      bus.rlast   = 1'b0;
      bus.rdata   = 32'd0;
      bus.rid     = 4'd0;
      bus.rresp   = 2'd0;
      beatIdx     = 1'b0;
      forever begin
         @(negedge clk);
         if (arreadyMode == 0) bus.arready = 1'($urandom_range(0, 1));
         else                  bus.arready = (arreadyMode == 1);
         bus.rresp = 2'($urandom);
         if (arQ.size() > 0 && !rHold && (rFull || $urandom_range(0, 99) < 70)) begin
            bus.rvalid = 1'b1;
            bus.rlast  = beatIdx;
            bus.rdata  = memRead(arQ[0] + (beatIdx ? 32'd4 : 32'd0));
         end else begin
            bus.rvalid = 1'b0;
            bus.rlast  = 1'b0;
            bus.rdata  = $urandom;
         end
         #1;
         if (rst) begin
            arQ.delete();
            beatIdx = 1'b0;
         end else begin
            if (bus.rvalid && bus.rready) begin
               if (bus.rlast) begin
                  void'(arQ.pop_front());
                  beatIdx = 1'b0;
               end else begin
                  beatIdx = 1'b1;
               end
            end
            if (bus.arvalid && bus.arready) arQ.push_back(bus.araddr);
         end
      end
   end

   // Reference model and per-cycle comparison.
   always @(negedge clk) begin : compare_proc
      logic        expAddrOk;
      logic        completion;
      logic        expDataOk;
      logic [63:0] expData;
      fetch_t      head;
      #2;
      cycleCnt++;
      if (rst) begin
         checkOutput("rst_arvalid", 64'(bus.arvalid), 64'd0);
         checkOutput("rst_araddr", 64'(bus.araddr), 64'd0);
         checkOutput("rst_rready", 64'(bus.rready), 64'd0);
         checkOutput("rst_data_ok", 64'(bus.inst_ram_data_ok), 64'd0);
         modelQ.delete();
         expArvalid = 1'b0;
         expAraddr  = 32'd0;
         expRready  = 1'b0;
      end else begin
         expAddrOk  = bus.inst_sram_req && (!expArvalid || bus.arready) && (modelQ.size() < MAX_OUT);
         completion = expRready && bus.rvalid && bus.rlast;
         expDataOk  = 1'b0;
         expData    = 64'd0;
         if (completion && modelQ.size() != 0) begin
            head      = modelQ.pop_front();
            expDataOk = !head.stale && !bus.excep_flush;
            expData   = {memRead(head.addr + 32'd4), memRead(head.addr)};
         end
         checkOutput("addr_ok", 64'(bus.inst_ram_addr_ok), 64'(expAddrOk));
         checkOutput("data_ok", 64'(bus.inst_ram_data_ok), 64'(expDataOk));
         if (expDataOk) checkOutput("rdata", bus.inst_ram_rdata, expData);
         checkOutput("arvalid", 64'(bus.arvalid), 64'(expArvalid));
         if (expArvalid) checkOutput("araddr", 64'(bus.araddr), 64'(expAraddr));
         checkOutput("rready", 64'(bus.rready), 64'(expRready));
         checkOutput("ar_fields", {49'd0, bus.arid, bus.arlen, bus.arsize}, {49'd0, 4'd0, 8'd1, 3'b010});
         checkOutput("arburst", 64'(bus.arburst), 64'd1);

         if (bus.inst_ram_addr_ok) begin
            addrOkCount++;
            lastAddrOkCycle = cycleCnt;
         end
         if (bus.inst_ram_data_ok) begin
            dataOkCount++;
            lastDataOkCycle = cycleCnt;
            lastRdata       = bus.inst_ram_rdata;
         end

         if (expAddrOk) begin
            modelQ.push_back('{addr: bus.inst_sram_raddr, stale: 1'b0});
            expArvalid = 1'b1;
            expAraddr  = bus.inst_sram_raddr;
         end else if (bus.arready) begin
            expArvalid = 1'b0;
         end
         if (bus.excep_flush) begin
            foreach (modelQ[i]) modelQ[i].stale = 1'b1;
         end
         expRready = 1'b1;
      end
   end

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic        acc;
      int          d0;
      int          a0;
      logic [31:0] nextAddr;

      rst                 = 1'b1;
      bus.inst_sram_req   = 1'b0;
      bus.inst_sram_raddr = 32'd0;
      bus.excep_flush     = 1'b0;
      arreadyMode         = 1;
      rHold               = 1'b0;
      rFull               = 1'b1;

      mem[32'h1c00_0000] = 32'h1111_1111;
      mem[32'h1c00_0004] = 32'h2222_2222;
      mem[32'h1c00_0010] = 32'h3333_3333;
      mem[32'h1c00_0014] = 32'h4444_4444;
      mem[32'h0000_0200] = 32'hAAAA_AAAA;
      mem[32'h0000_0204] = 32'hBBBB_BBBB;
      mem[32'h0000_0700] = 32'h7070_7070;
      mem[32'h0000_0704] = 32'h7474_7474;

      doReset();
      waitIdle();

      $display("[TB] single fetch");
      d0 = dataOkCount;
      fetchOne(32'h1c00_0000);
      applyStimulus(1'b0, 32'd0, 1'b0, acc);
      checkOutput("t1_arvalid", 64'(bus.arvalid), 64'd1);
      checkOutput("t1_araddr", 64'(bus.araddr), 64'h1c00_0000);
      checkOutput("t1_arlen", 64'(bus.arlen), 64'd1);
      waitIdle();
      checkOutput("t1_data_ok_count", 64'(dataOkCount - d0), 64'd1);
      checkOutput("t1_rdata", lastRdata, 64'h2222_2222_1111_1111);
      checkOutput("t1_latency", 64'(lastDataOkCycle - lastAddrOkCycle), 64'd3);

      $display("[TB] backpressure");
      arreadyMode = 2;
      rHold       = 1'b1;
      a0          = addrOkCount;
      d0          = dataOkCount;
      nextAddr    = 32'h300;
      for (int i = 0; i < 6; i++) begin
         applyStimulus(1'b1, nextAddr, 1'b0, acc);
         if (acc) nextAddr = nextAddr + 32'd8;
      end
      checkOutput("bp_one_accept", 64'(addrOkCount - a0), 64'd1);
      checkOutput("bp_araddr_held", 64'(bus.araddr), 64'h300);
      arreadyMode = 1;
      applyStimulus(1'b1, nextAddr, 1'b0, acc);
      checkOutput("bp_accept_on_arready", 64'(acc), 64'd1);
      nextAddr = nextAddr + 32'd8;
      for (int i = 0; i < 5; i++) applyStimulus(1'b1, nextAddr, 1'b0, acc);
      checkOutput("bp_capped_at_max", 64'(addrOkCount - a0), 64'd2);
      rHold = 1'b0;
      waitIdle();
      checkOutput("bp_data_ok_count", 64'(dataOkCount - d0), 64'd2);

      $display("[TB] flush with two in flight");
      rHold = 1'b1;
      d0    = dataOkCount;
      fetchOne(32'h100);
      fetchOne(32'h108);
      applyStimulus(1'b0, 32'd0, 1'b1, acc);
      rHold = 1'b0;
      fetchOne(32'h200);
      waitIdle();
      checkOutput("fl2_data_ok_count", 64'(dataOkCount - d0), 64'd1);
      checkOutput("fl2_rdata", lastRdata, 64'hBBBB_BBBB_AAAA_AAAA);

      $display("[TB] accept and rlast in the same cycle");
      rHold = 1'b1;
      d0    = dataOkCount;
      fetchOne(32'h400);
      applyStimulus(1'b0, 32'd0, 1'b0, acc);
      applyStimulus(1'b0, 32'd0, 1'b0, acc);
      rHold = 1'b0;
      applyStimulus(1'b0, 32'd0, 1'b0, acc);
      applyStimulus(1'b1, 32'h500, 1'b0, acc);
      checkOutput("sim_accept", 64'(acc), 64'd1);
      checkOutput("sim_data_ok", 64'(bus.inst_ram_data_ok), 64'd1);
      waitIdle();
      checkOutput("sim_data_ok_count", 64'(dataOkCount - d0), 64'd2);

      $display("[TB] flush coinciding with rlast");
      rHold = 1'b1;
      d0    = dataOkCount;
      fetchOne(32'h600);
      applyStimulus(1'b0, 32'd0, 1'b0, acc);
      applyStimulus(1'b0, 32'd0, 1'b0, acc);
      rHold = 1'b0;
      applyStimulus(1'b0, 32'd0, 1'b0, acc);
      applyStimulus(1'b0, 32'd0, 1'b1, acc);
      checkOutput("flr_data_ok", 64'(bus.inst_ram_data_ok), 64'd0);
      fetchOne(32'h700);
      waitIdle();
      checkOutput("flr_data_ok_count", 64'(dataOkCount - d0), 64'd1);
      checkOutput("flr_rdata", lastRdata, 64'h7474_7474_7070_7070);

      $display("[TB] reset between beats");
      rHold = 1'b1;
      d0    = dataOkCount;
      fetchOne(32'h1c00_0010);
      applyStimulus(1'b0, 32'd0, 1'b0, acc);
      applyStimulus(1'b0, 32'd0, 1'b0, acc);
      rHold = 1'b0;
      applyStimulus(1'b0, 32'd0, 1'b0, acc);
      doReset();
      fetchOne(32'h1c00_0010);
      waitIdle();
      checkOutput("rst_mid_data_ok_count", 64'(dataOkCount - d0), 64'd1);
      checkOutput("rst_mid_rdata", lastRdata, 64'h4444_4444_3333_3333);

      $display("[TB] random traffic");
      arreadyMode = 0;
      rFull       = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         applyStimulus(1'($urandom_range(0, 99) < 60),
                       {16'h1c00, 14'($urandom), 2'b00},
                       1'($urandom_range(0, 99) < 3), acc);
      end
      waitIdle();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/inst_sram_axi_rd_bridge.md
Name: inst_sram_axi_rd_bridge

Overview:
- Responder end of the instruction-fetch SRAM-like interface.
- Accepts fetch requests (req/addr) from the pre-fetch stage and answers with addr_ok.
- Converts each accepted request into a 2-beat AXI read of pc and pc+4, and returns a 64-bit instruction pair with data_ok.
- Sits between the front end and the AXI crossbar. Handles pipeline flush by discarding responses to requests already in flight.

Parameters:
- MAX_OUT, 2, maximum requests accepted but not yet returned (1..3).
- AXI_ID, 4'd0, fixed ARID for instruction reads.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- inst_sram_req_i  in  1  fetch request valid
- inst_sram_raddr_i  in  32  fetch address, word aligned
- excep_flush_i  in  1  pipeline flush; in-flight fetches become stale
- inst_ram_addr_ok_o  out  1  request accepted this cycle
- inst_ram_data_ok_o  out  1  instruction pair valid this cycle
- inst_ram_rdata_o  out  64  {inst@pc+4, inst@pc}
- arid_o  out  4  = AXI_ID
- araddr_o  out  32  read address
- arlen_o  out  8  = 8'd1
- arsize_o  out  3  = 3'b010
- arburst_o  out  2  = 2'b01 (INCR)
- arvalid_o  out  1  AR valid
- arready_i  in  1  AR ready
- rid_i  in  4  ignored (single ID, in order)
- rdata_i  in  32  read beat data
- rresp_i  in  2  ignored
- rlast_i  in  1  last beat
- rvalid_i  in  1  R valid
- rready_o  out  1  constant 1 after reset

Behaviour:
Reset:
- arvalid_o, araddr_o, rready_o, data_ok, the outstanding counter, the cancel counter and the beat state all reset to 0.
- rready_o goes to 1 in the first cycle after reset is released.
- Asserting rst mid-burst abandons all state. The bench must also reset the AXI slave.

Accept rule (combinational):
- addr_ok = req & (!arvalid_q | arready_i) & (out_cnt < MAX_OUT).
- On addr_ok: araddr_q <= raddr and arvalid_q <= 1 in the next cycle.
- arvalid_q holds with a stable address until arready_i, per AXI rules.
- If arready_i=1 and no new accept, arvalid_q <= 0.

Outstanding counter out_cnt:
- +1 on addr_ok, -1 on the rlast handshake.
- Both in the same cycle: unchanged.
- It never exceeds MAX_OUT; when it equals MAX_OUT, addr_ok is forced to 0.

Beat FSM:
- BEAT0: a handshake (rvalid_i) stores rdata_i into lo_q and moves to BEAT1.
- BEAT1: a handshake with rlast_i completes the pair and returns to BEAT0.
- A beat arriving in BEAT0 with rlast_i=1 is a protocol error. It is treated as completion with hi = rdata_i and lo = lo_q.

Completion:
- data_ok is combinational in the rlast handshake cycle.
- rdata_o = {rdata_i, lo_q}.
- data_ok is suppressed when the completion is stale (see Flush).

Flush:
- In a cycle with excep_flush_i=1: cancel_cnt <= out_cnt_next, the count after this cycle's accept and complete.
- Completions in the flush cycle itself are also suppressed.
- Later, each completion while cancel_cnt>0 suppresses data_ok and decrements cancel_cnt.
- A second flush overwrites cancel_cnt with the current out_cnt_next.
- AR transactions are never withdrawn; a pending arvalid_q completes normally and is counted as stale.

Ordering and errors:
- Responses are strictly in order; rid_i is not checked.
- rresp errors are not reported; data is returned as is.
- Latency floor: addr_ok in cycle T, arvalid in T+1, earliest data_ok in T+3 with a zero-wait slave.

Decomposition:
- Shared package (DefineModuleBus.h side): AXI_BURST_INCR, AXI_SIZE_WORD, ARID_INST, InstPairWidth=64.
- One natural sub-module: inst_rbeat_pack (BEAT0/BEAT1 FSM plus lo_q, outputs pair_done and pair_data).
- Counters and the AR register stay in the top level.

Test Plan:
- Single fetch: req, addr=0x1c000000, arready=1, slave returns 0x11111111 then 0x22222222 (rlast) -> addr_ok at T, araddr=0x1c000000 with arlen=1 at T+1, data_ok with rdata=0x22222222_11111111 exactly once.
- Backpressure: req held high, arready=0 for 5 cycles, MAX_OUT=2 -> addr_ok once, arvalid and araddr stable for 5 cycles, second addr_ok only in the arready cycle, no third addr_ok until a completion.
- Flush with 2 in flight: accept 0x100 and 0x108, assert excep_flush_i, then accept 0x200 -> first two completions give data_ok=0, the 0x200 completion gives data_ok=1 with its data.
- Simultaneous accept and rlast at out_cnt=MAX_OUT-1 -> out_cnt unchanged; addr_ok legal that cycle; data_ok=1.
- Flush in the same cycle as a rlast beat, with 1 outstanding -> data_ok=0 that cycle; cancel_cnt=0 afterwards; next request returns normally.
- Reset asserted between beat 0 and beat 1 -> all outputs 0 immediately; after release, a fresh fetch completes with correct data.
